// File: rtl/sample_circuit_pkg.sv
// Shared constants and golden helper functions for the sample_circuit block:
// lookup tables, implementation-style selectors and reference functions.
package sample_circuit_pkg;

  localparam int C_MODE_GATE = 0;
  localparam int C_MODE_CASE = 1;
  localparam int C_MODE_LUT  = 2;

  // Bit i holds the function value for input word i.
  localparam logic [15:0] C_PARITY_LUT = 16'h6996;
  localparam logic [15:0] C_PRIME_LUT  = 16'h28AC;

  function automatic logic f_parity(input logic [3:0] d);
    return d[3] ^ d[2] ^ d[1] ^ d[0];
  endfunction

  function automatic logic f_prime(input logic [3:0] d);
    logic r;
    case (d)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sample_circuit_logic.sv
// Combinational core: odd parity and "is prime" of a 4-bit word, built in one
// of three interchangeable styles chosen at elaboration by G_MODE.
module sample_circuit_logic
  import sample_circuit_pkg::*;
#(
  parameter int G_MODE = 0
) (
  input  logic [3:0] D,
  output logic       QX_NEXT,
  output logic       QY_NEXT
);

  generate
    if (G_MODE == C_MODE_GATE) begin : g_gate
      logic w_d3_n;
      logic w_d2_n;
      logic w_d1_n;

      assign w_d3_n  = ~D[3];
      assign w_d2_n  = ~D[2];
      assign w_d1_n  = ~D[1];
      assign QX_NEXT = D[3] ^ D[2] ^ D[1] ^ D[0];
      assign QY_NEXT = (w_d3_n & w_d2_n & D[1]) |
                       (w_d3_n & D[2]   & D[0]) |
                       (w_d2_n & D[1]   & D[0]) |
                       (D[2]   & w_d1_n & D[0]);
    end else if (G_MODE == C_MODE_CASE) begin : g_case
      logic [1:0] w_xy;

      // Explicit truth table, every input word listed as {QX,QY}.
      always_comb begin
        w_xy = 2'b00;
        case (D)
          4'd0:    w_xy = 2'b00;
          4'd1:    w_xy = 2'b10;
          4'd2:    w_xy = 2'b11;
          4'd3:    w_xy = 2'b01;
          4'd4:    w_xy = 2'b10;
          4'd5:    w_xy = 2'b01;
          4'd6:    w_xy = 2'b00;
          4'd7:    w_xy = 2'b11;
          4'd8:    w_xy = 2'b10;
          4'd9:    w_xy = 2'b00;
          4'd10:   w_xy = 2'b00;
          4'd11:   w_xy = 2'b11;
          4'd12:   w_xy = 2'b00;
          4'd13:   w_xy = 2'b11;
          4'd14:   w_xy = 2'b10;
          4'd15:   w_xy = 2'b00;
          default: w_xy = 2'b00;
        endcase
      end

      assign QX_NEXT = w_xy[1];
      assign QY_NEXT = w_xy[0];
    end else if (G_MODE == C_MODE_LUT) begin : g_lut
      assign QX_NEXT = C_PARITY_LUT[D];
      assign QY_NEXT = C_PRIME_LUT[D];
    end else begin : g_bad
      $error("sample_circuit_logic: unsupported G_MODE %0d", G_MODE);
      assign QX_NEXT = 1'b0;
      assign QY_NEXT = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sample_circuit.sv
// Registered parity / prime sample circuit: combinational core followed by
// two output flops with synchronous active-high reset (one cycle latency).
module sample_circuit
  import sample_circuit_pkg::*;
#(
  parameter int G_MODE = C_MODE_GATE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] D,
  output logic       QX,
  output logic       QY
);

  logic w_qx_next;
  logic w_qy_next;
  logic r_qx;
  logic r_qy;

  sample_circuit_logic #(
    .G_MODE (G_MODE)
  ) u_logic (
    .D       (D),
    .QX_NEXT (w_qx_next),
    .QY_NEXT (w_qy_next)
  );

  // Output flops; reset discards the word sampled on that edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_qx <= 1'b0;
      r_qy <= 1'b0;
    end else begin
      r_qx <= w_qx_next;
      r_qy <= w_qy_next;
    end
  end

  assign QX = r_qx;
  assign QY = r_qy;

endmodule

// File: tb/tb_sample_circuit.sv
// Self-checking bench: three sample_circuit instances (one per style) driven
// in lockstep and compared against an arithmetic reference model.
module tb_sample_circuit;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       qx_s [3];
  logic       qy_s [3];

  int n_checks;
  int n_errors;

  sample_circuit #(.G_MODE(0)) u_gate (.CLK(clk), .RST(rst), .D(d), .QX(qx_s[0]), .QY(qy_s[0]));
  sample_circuit #(.G_MODE(1)) u_case (.CLK(clk), .RST(rst), .D(d), .QX(qx_s[1]), .QY(qy_s[1]));
  sample_circuit #(.G_MODE(2)) u_lut  (.CLK(clk), .RST(rst), .D(d), .QX(qx_s[2]), .QY(qy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count ones, and trial division for primality.
  function automatic logic m_parity(input int n);
    return ($countones(n) % 2) == 1;
  endfunction

  function automatic logic m_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) begin
      if (n % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed {QX,QY}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] exp);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("%s/mode%0d", tag, m), {qx_s[m], qy_s[m]}, exp);
    end
  endtask

  // Apply one word, clock it in, then check outputs just after the edge.
  task automatic step(input string tag, input logic r, input logic [3:0] v, input logic [1:0] exp);
    rst = r;
    d   = v;
    @(posedge clk);
    #1;
    check_all(tag, exp);
  endtask

  int         qx_seq [16] = '{0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0};
  int         qy_seq [16] = '{0,0,1,1,0,1,0,1,0,0,0,1,0,1,0,0};
  logic       r_rand;
  logic [3:0] d_rand;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    d   = 4'hF;

    step("reset1", 1'b1, 4'hF, 2'b00);
    step("reset2", 1'b1, 4'hF, 2'b00);

    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0d", i), 1'b0, 4'(i), {qx_seq[i][0], qy_seq[i][0]});
    end

    step("lat_d0", 1'b0, 4'd0, 2'b00);
    d = 4'd13;
    #2;
    check_all("lat_early", 2'b00);
    step("lat_d13", 1'b0, 4'd13, 2'b11);

    step("mid_pre", 1'b0, 4'd7, 2'b11);
    step("mid_rst", 1'b1, 4'd7, 2'b00);
    step("mid_post", 1'b0, 4'd7, 2'b11);

    // A reset pulse between edges must not reach the flops.
    d   = 4'd5;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("glitch_rst", 2'b01);

    for (int i = 0; i < 1000; i++) begin
      d_rand = 4'($urandom_range(0, 15));
      r_rand = ($urandom_range(0, 31) == 0);
      step("rand", r_rand, d_rand,
           r_rand ? 2'b00 : {m_parity(int'(d_rand)), m_prime(int'(d_rand))});
    end

    step("bnd_F", 1'b0, 4'hF, 2'b00);
    step("bnd_0", 1'b0, 4'h0, 2'b00);
    step("bnd_1", 1'b0, 4'h1, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
